aes_byte_packer: RTL and testbench

//  Upstream feeder for the 10-round pipelined AES-128 encryptor.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_valid_delay.sv | 36 +++
 rtl/aes_byte_packer.sv | 134 +++++++++++++
 tb/tb_aes_byte_packer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared widths, latency and FSM encodings for the AES feeder path.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLK_W    = 128;
    localparam int AES_KEY_W    = 128;
    localparam int AES_PIPE_LAT = 10;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_EMIT = 1'b1
    } packState_t;

    // Byte idx 0 lands in the most significant byte of the block.
    function automatic logic [AES_BLK_W-1:0] placeByte(
        input logic [AES_BLK_W-1:0] blk,
        input logic [3:0]           idx,
        input logic [7:0]           b
    );
        logic [AES_BLK_W-1:0] res;
        res = blk;
        res[(AES_BLK_W - 8) - 8 * int'(idx) +: 8] = b;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_valid_delay.sv
`default_nettype none
// ============================================================================
// Module   : aes_valid_delay
// Brief    : DEPTH-stage shift register that mirrors the encryptor latency.
// Revision : 1.0 - initial release
// ============================================================================
module aes_valid_delay #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_pipe[i] <= '0;
                else        r_pipe[i] <= i_data;
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_pipe[i] <= '0;
                else        r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/aes_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : aes_byte_packer
// Brief    : Packs a byte stream into 128-bit AES blocks, holds the key and
//            delays {valid, tag} to line up with the encryptor output.
//            Optional idle flush of partial blocks: AES_PACK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_byte_packer
    import aes_pkg::*;
#(
    parameter int PIPE_LAT    = AES_PIPE_LAT,
    parameter int TAG_W       = 8,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           i_byte,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [AES_KEY_W-1:0] i_key,
    input  logic                 i_key_load,
    output logic [AES_BLK_W-1:0] o_plaintext,
    output logic [AES_KEY_W-1:0] o_key,
    output logic                 o_blk_valid,
    output logic                 o_ct_valid,
    output logic [TAG_W-1:0]     o_ct_tag
);

    packState_t           r_state;
    logic [3:0]           r_byteCount;
    logic [AES_BLK_W-1:0] r_buffer;
    logic [AES_BLK_W-1:0] r_plaintext;
    logic [AES_KEY_W-1:0] r_key;
    logic                 r_ready;
    logic                 r_blkValid;
    logic [TAG_W-1:0]     r_tagCount;
    logic [TAG_W-1:0]     r_blkTag;

    logic                 w_xfer;
    logic                 w_lastByte;
    logic                 w_timeout;
    logic [AES_BLK_W-1:0] w_filled;
    logic [TAG_W:0]       w_delayOut;

    assign w_xfer     = i_valid && r_ready;
    assign w_lastByte = w_xfer && (r_byteCount == 4'd15);
    assign w_filled   = placeByte(r_buffer, r_byteCount, i_byte);

`ifdef AES_PACK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] r_idleCount;

    assign w_timeout = (r_state == S_FILL) && !w_xfer && (r_byteCount != 4'd0)
                    && (r_idleCount == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idleCount <= '0;
        end else if (w_xfer || w_timeout || (r_byteCount == 4'd0) || (r_state != S_FILL)) begin
            r_idleCount <= '0;
        end else begin
            r_idleCount <= r_idleCount + IDLE_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_byteCount <= 4'd0;
            r_buffer    <= '0;
            r_plaintext <= '0;
            r_key       <= '0;
            r_ready     <= 1'b0;
            r_blkValid  <= 1'b0;
            r_tagCount  <= '0;
            r_blkTag    <= '0;
        end else begin
            // Same-edge key load is visible alongside a block emitted on this edge.
            if (i_key_load) r_key <= i_key;

            case (r_state)
                S_FILL: begin
                    r_ready <= 1'b1;
                    if (w_lastByte || w_timeout) begin
                        // Buffer is cleared after every block, so a flush is zero-padded.
                        r_plaintext <= w_lastByte ? w_filled : r_buffer;
                        r_buffer    <= '0;
                        r_byteCount <= 4'd0;
                        r_blkValid  <= 1'b1;
                        r_ready     <= 1'b0;
                        r_blkTag    <= r_tagCount;
                        r_tagCount  <= r_tagCount + TAG_W'(1);
                        r_state     <= S_EMIT;
                    end else if (w_xfer) begin
                        r_buffer    <= w_filled;
                        r_byteCount <= r_byteCount + 4'd1;
                    end
                end
                S_EMIT: begin
                    r_blkValid <= 1'b0;
                    r_ready    <= 1'b1;
                    r_state    <= S_FILL;
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    aes_valid_delay #(
        .DEPTH (PIPE_LAT),
        .WIDTH (TAG_W + 1)
    ) u_validDelay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data ({r_blkValid, r_blkTag}),
        .o_data (w_delayOut)
    );

    assign o_ready     = r_ready;
    assign o_plaintext = r_plaintext;
    assign o_key       = r_key;
    assign o_blk_valid = r_blkValid;
    assign o_ct_valid  = w_delayOut[TAG_W];
    assign o_ct_tag    = w_delayOut[TAG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_aes_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_byte_packer
// Brief    : Self-checking bench for aes_byte_packer with a block scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_byte_packer;

    localparam int TAG_W    = 8;
    localparam int PIPE_LAT = 10;
    localparam int TMO      = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   i_byte;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_key;
    logic         i_key_load;
    logic [127:0] o_plaintext;
    logic [127:0] o_key;
    logic         o_blk_valid;
    logic         o_ct_valid;
    logic [7:0]   o_ct_tag;

    aes_byte_packer #(
        .PIPE_LAT    (PIPE_LAT),
        .TAG_W       (TAG_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_byte      (i_byte),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_key       (i_key),
        .i_key_load  (i_key_load),
        .o_plaintext (o_plaintext),
        .o_key       (o_key),
        .o_blk_valid (o_blk_valid),
        .o_ct_valid  (o_ct_valid),
        .o_ct_tag    (o_ct_tag)
    );

    always #5 clk = ~clk;

    int checkCnt = 0;
    int passCnt  = 0;
    int cyc      = 0;
    int stallCnt = 0;

    logic [127:0] ptQ[$];
    logic [127:0] keyQ[$];
    logic [7:0]   tagQ[$];
    int           ctTimes[$];
    logic [7:0]   ctTags[$];

    logic [127:0] expKey;
    logic [7:0]   expTag;
    logic [127:0] monPt;
    logic [127:0] monKey;
    logic [7:0]   monTag;

    always @(posedge clk) cyc++;

    // Scoreboard: blocks and ciphertext tags are popped as the DUT reports them.
    always @(negedge clk) begin
        if (rst_n && o_blk_valid) begin
            if (ptQ.size() == 0) begin
                checkCnt++;
                $display("FAIL blk_unexpected: o_blk_valid=1 plaintext=%h, no block expected", o_plaintext);
            end else begin
                monPt  = ptQ.pop_front();
                monKey = keyQ.pop_front();
                checkCnt++;
                if (o_plaintext !== monPt)
                    $display("FAIL blk_plaintext: got %h expected %h", o_plaintext, monPt);
                else passCnt++;
                checkCnt++;
                if (o_key !== monKey)
                    $display("FAIL blk_key: got %h expected %h", o_key, monKey);
                else passCnt++;
            end
        end
        if (rst_n && o_ct_valid) begin
            ctTimes.push_back(cyc);
            ctTags.push_back(o_ct_tag);
            checkCnt++;
            if (tagQ.size() == 0) begin
                $display("FAIL ct_unexpected: o_ct_valid=1 tag=%0d, none expected", o_ct_tag);
            end else begin
                monTag = tagQ.pop_front();
                if (o_ct_tag !== monTag)
                    $display("FAIL ct_tag: got %0d expected %0d", o_ct_tag, monTag);
                else passCnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic rdy;
        int   n;
        n       = 0;
        i_byte  = b;
        i_valid = 1'b1;
        forever begin
            rdy = o_ready;
            tick();
            if (rdy) break;
            stallCnt++;
            n++;
            if (n > 50) begin
                checkCnt++;
                $display("FAIL send_timeout: o_ready=%b after %0d cycles, expected 1", o_ready, n);
                break;
            end
        end
    endtask

    task automatic pushExpected(input logic [127:0] blk);
        ptQ.push_back(blk);
        keyQ.push_back(expKey);
        tagQ.push_back(expTag);
        expTag = expTag + 8'd1;
    endtask

    task automatic sendBlock(input logic [127:0] blk, input logic race, input logic [127:0] newKey);
        for (int i = 0; i < 16; i++) begin
            if (i == 15 && race) begin
                i_key      = newKey;
                i_key_load = 1'b1;
                expKey     = newKey;
            end
            sendByte(blk[127 - 8*i -: 8]);
        end
        i_key_load = 1'b0;
        pushExpected(blk);
    endtask

    task automatic loadKey(input logic [127:0] k);
        i_key      = k;
        i_key_load = 1'b1;
        tick();
        i_key_load = 1'b0;
        expKey     = k;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [127:0] randBlk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic doReset();
        i_valid    = 1'b0;
        i_key_load = 1'b0;
        rst_n      = 1'b0;
        ptQ.delete(); keyQ.delete(); tagQ.delete();
        expTag = 8'd0;
        expKey = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_byte = '0; i_key = '0; i_key_load = 1'b0;
        expKey = '0; expTag = 8'd0;
        #12;
        checkCnt++;
        if ({o_ready, o_blk_valid, o_ct_valid, o_ct_tag} !== 11'd0)
            $display("FAIL reset_ctrl: got rdy=%b blk=%b ct=%b tag=%0d, expected all 0",
                     o_ready, o_blk_valid, o_ct_valid, o_ct_tag);
        else passCnt++;
        checkCnt++;
        if ({o_plaintext, o_key} !== 256'd0)
            $display("FAIL reset_data: got pt=%h key=%h, expected 0", o_plaintext, o_key);
        else passCnt++;
        #1 rst_n = 1'b1;
        tick();
        checkCnt++;
        if (o_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", o_ready);
        else passCnt++;
    endtask

    task automatic test_fips();
        int n;
        loadKey(128'h000102030405060708090a0b0c0d0e0f);
        sendBlock(128'h00112233445566778899aabbccddeeff, 1'b0, '0);
        i_valid = 1'b0;
        checkCnt++;
        if (o_blk_valid !== 1'b1 || o_plaintext !== 128'h00112233445566778899aabbccddeeff)
            $display("FAIL fips_block: got valid=%b pt=%h expected 1/00112233445566778899aabbccddeeff",
                     o_blk_valid, o_plaintext);
        else passCnt++;
        n = 0;
        while (!o_ct_valid && n < 20) begin tick(); n++; end
        checkCnt++;
        if (n !== PIPE_LAT || o_ct_tag !== 8'd0)
            $display("FAIL fips_ct_latency: got %0d cycles tag %0d expected %0d cycles tag 0",
                     n, o_ct_tag, PIPE_LAT);
        else passCnt++;
        idle(5);
    endtask

    task automatic test_streaming();
        doReset();
        loadKey(randBlk());
        stallCnt = 0;
        ctTimes.delete(); ctTags.delete();
        for (int b = 0; b < 3; b++) sendBlock(randBlk(), 1'b0, '0);
        checkCnt++;
        if (o_ready !== 1'b0) $display("FAIL stream_emit_ready: got %b expected 0", o_ready);
        else passCnt++;
        idle(1);
        checkCnt++;
        if (o_ready !== 1'b1 || stallCnt !== 2)
            $display("FAIL stream_stalls: got ready=%b stalls=%0d expected 1/2", o_ready, stallCnt);
        else passCnt++;
        idle(15);
        checkCnt++;
        if (ctTimes.size() !== 3)
            $display("FAIL stream_ct_count: got %0d expected 3", ctTimes.size());
        else if (ctTimes[1] - ctTimes[0] !== 17 || ctTimes[2] - ctTimes[1] !== 17)
            $display("FAIL stream_spacing: got %0d,%0d expected 17,17",
                     ctTimes[1] - ctTimes[0], ctTimes[2] - ctTimes[1]);
        else if (ctTags[0] !== 8'd0 || ctTags[1] !== 8'd1 || ctTags[2] !== 8'd2)
            $display("FAIL stream_tags: got %0d,%0d,%0d expected 0,1,2", ctTags[0], ctTags[1], ctTags[2]);
        else passCnt++;
    endtask

    task automatic test_key_race();
        logic [127:0] k2;
        k2 = 128'hfeedface_0badf00d_deadbeef_12345678;
        loadKey(128'h11111111_22222222_33333333_44444444);
        sendBlock(randBlk(), 1'b1, k2);
        i_valid = 1'b0;
        checkCnt++;
        if (o_blk_valid !== 1'b1 || o_key !== k2)
            $display("FAIL key_race: got valid=%b key=%h expected 1/%h", o_blk_valid, o_key, k2);
        else passCnt++;
        idle(15);
    endtask

    task automatic test_reset_mid();
        logic [127:0] blk;
        int           seen;
        sendBlock(randBlk(), 1'b0, '0);
        idle(3);
        for (int i = 0; i < 7; i++) sendByte(8'h50 + 8'(i));
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkCnt++;
        if ({o_ready, o_blk_valid, o_ct_valid, o_ct_tag, o_plaintext, o_key} !== 267'd0)
            $display("FAIL reset_mid_outputs: got rdy=%b ct=%b tag=%0d pt=%h key=%h expected all 0",
                     o_ready, o_ct_valid, o_ct_tag, o_plaintext, o_key);
        else passCnt++;
        doReset();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (o_ct_valid) seen++;
        end
        checkCnt++;
        if (seen !== 0) $display("FAIL reset_inflight: got %0d ct_valid pulses expected 0", seen);
        else passCnt++;
        blk = randBlk();
        sendBlock(blk, 1'b0, '0);
        i_valid = 1'b0;
        checkCnt++;
        if (o_plaintext !== blk) $display("FAIL reset_repack: got %h expected %h", o_plaintext, blk);
        else passCnt++;
        idle(15);
    endtask

    task automatic test_tag_wrap();
        doReset();
        loadKey(randBlk());
        ctTags.delete();
        for (int b = 0; b < 257; b++) sendBlock(randBlk(), 1'b0, '0);
        idle(15);
        checkCnt++;
        if (ctTags.size() !== 257)
            $display("FAIL wrap_count: got %0d expected 257", ctTags.size());
        else if (ctTags[254] !== 8'd254 || ctTags[255] !== 8'd255 || ctTags[256] !== 8'd0)
            $display("FAIL wrap_tags: got %0d,%0d,%0d expected 254,255,0",
                     ctTags[254], ctTags[255], ctTags[256]);
        else passCnt++;
    endtask

`ifdef AES_PACK_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        for (int i = 0; i < 5; i++) sendByte(8'ha1 + 8'(i));
        i_valid = 1'b0;
        pushExpected({40'ha1a2a3a4a5, 88'd0});
        n = 0;
        while (!o_blk_valid && n < 30) begin tick(); n++; end
        checkCnt++;
        if (n !== TMO || o_plaintext !== {40'ha1a2a3a4a5, 88'd0})
            $display("FAIL timeout_flush: got %0d cycles pt=%h expected %0d cycles a1a2a3a4a5+zeros",
                     n, o_plaintext, TMO);
        else passCnt++;
        idle(15);
    endtask
`endif

    initial begin
        test_reset();
        test_fips();
        test_streaming();
        test_key_race();
        test_reset_mid();
        test_tag_wrap();
`ifdef AES_PACK_TIMEOUT_EN
        test_timeout();
`endif
        idle(5);
        checkCnt++;
        if (ptQ.size() !== 0 || tagQ.size() !== 0)
            $display("FAIL scoreboard_drain: got %0d blocks %0d tags pending expected 0",
                     ptQ.size(), tagQ.size());
        else passCnt++;
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
`default_nettype wire
